// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer for the PLL-clocked vision fabric: qualifies PLL lock and
// init completion, then releases the fabric reset and the pipeline reset in turn.
module pll_lock_reset_seq #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGGER_CYCLES     = 16,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic                  PLL_LOCK,
   input  logic                  INIT_DONE,
   input  logic                  LOSS_CLR,
   output logic                  FABRIC_RESET_N,
   output logic                  PIPE_RESET_N,
   output logic                  LOCK_STABLE,
   output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

   typedef enum logic [1:0] {
      S_WAIT_LOCK,
      S_STAGGER,
      S_RUN,
      S_LOCK_LOST
   } state_t;

   localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [7:0]  STAGGER_LAST = 8'(STAGGER_CYCLES - 1);

   function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
      return (&v) ? v : v + LOSS_CNT_W'(1);
   endfunction

   logic [SYNC_STAGES-1:0] lock_sync;
   logic [SYNC_STAGES-1:0] init_sync;
   logic                   lock_s;
   logic                   init_s;

   state_t                 state;
   state_t                 state_nxt;
   logic [15:0]            stable_cnt;
   logic [15:0]            stable_cnt_nxt;
   logic [7:0]             stagger_cnt;
   logic [7:0]             stagger_cnt_nxt;
   logic                   loss_inc;
   logic                   fabric_nxt;
   logic                   pipe_nxt;
   logic [LOSS_CNT_W-1:0]  loss_nxt;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         lock_sync <= '0;
         init_sync <= '0;
      end else begin
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], PLL_LOCK};
         init_sync <= {init_sync[SYNC_STAGES-2:0], INIT_DONE};
      end
   end

   assign lock_s = lock_sync[SYNC_STAGES-1];
   assign init_s = init_sync[SYNC_STAGES-1];

   always_comb begin
      state_nxt       = state;
      stable_cnt_nxt  = '0;
      stagger_cnt_nxt = '0;
      loss_inc        = 1'b0;
      case (state)
         S_WAIT_LOCK: begin
            if (lock_s && init_s) begin
               if (stable_cnt == STABLE_LAST) state_nxt = S_STAGGER;
               else stable_cnt_nxt = stable_cnt + 16'd1;
            end
         end
         S_STAGGER: begin
            if (!lock_s) begin
               state_nxt = S_LOCK_LOST;
               loss_inc  = 1'b1;
            end else if (stagger_cnt == STAGGER_LAST) begin
               state_nxt = S_RUN;
            end else begin
               stagger_cnt_nxt = stagger_cnt + 8'd1;
            end
         end
         S_RUN: begin
            if (!lock_s) begin
               state_nxt = S_LOCK_LOST;
               loss_inc  = 1'b1;
            end
         end
         S_LOCK_LOST: state_nxt = S_WAIT_LOCK;
         default:     state_nxt = S_WAIT_LOCK;
      endcase

      // Outputs are registered from the next state so they leave flops directly.
      fabric_nxt = (state_nxt == S_STAGGER) || (state_nxt == S_RUN);
      pipe_nxt   = (state_nxt == S_RUN);

      loss_nxt = LOSS_CNT;
      if (LOSS_CLR)      loss_nxt = '0;
      else if (loss_inc) loss_nxt = sat_inc(LOSS_CNT);
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state          <= S_WAIT_LOCK;
         stable_cnt     <= '0;
         stagger_cnt    <= '0;
         FABRIC_RESET_N <= 1'b0;
         PIPE_RESET_N   <= 1'b0;
         LOCK_STABLE    <= 1'b0;
         LOSS_CNT       <= '0;
      end else begin
         state          <= state_nxt;
         stable_cnt     <= stable_cnt_nxt;
         stagger_cnt    <= stagger_cnt_nxt;
         FABRIC_RESET_N <= fabric_nxt;
         PIPE_RESET_N   <= pipe_nxt;
         LOCK_STABLE    <= fabric_nxt;
         LOSS_CNT       <= loss_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios plus random lock/init
// activity, every cycle compared against a release/age-based reference model.
module tb_pll_lock_reset_seq;

   localparam int SYNC     = 2;
   localparam int LSC      = 1024;
   localparam int STG      = 16;
   localparam int LW       = 2;
   localparam int LOSS_MAX = (1 << LW) - 1;

   logic          CLK;
   logic          RESETN;
   logic          PLL_LOCK;
   logic          INIT_DONE;
   logic          LOSS_CLR;
   logic          FABRIC_RESET_N;
   logic          PIPE_RESET_N;
   logic          LOCK_STABLE;
   logic [LW-1:0] LOSS_CNT;

   pll_lock_reset_seq #(
      .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC),
      .STAGGER_CYCLES(STG), .LOSS_CNT_W(LW)
   ) dut (
      .CLK(CLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .INIT_DONE(INIT_DONE),
      .LOSS_CLR(LOSS_CLR), .FABRIC_RESET_N(FABRIC_RESET_N),
      .PIPE_RESET_N(PIPE_RESET_N), .LOCK_STABLE(LOCK_STABLE), .LOSS_CNT(LOSS_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model: input history, whether the fabric has been released,
   // how long ago, the current qualifying run length and the dead cycle after a loss.
   bit m_lock_q[$];
   bit m_init_q[$];
   bit m_rel;
   int m_age;
   int m_qual;
   bit m_dead;
   int m_loss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %0h, want %0h (t=%0t)", tag, cyc, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({FABRIC_RESET_N, PIPE_RESET_N, LOCK_STABLE, LOSS_CNT});
   endfunction

   function automatic logic [31:0] model_outs();
      bit pipe;
      pipe = m_rel && (m_age >= STG);
      return 32'({m_rel, pipe, m_rel, LW'(m_loss)});
   endfunction

   function automatic void model_reset();
      m_lock_q.delete();
      m_init_q.delete();
      for (int i = 0; i < SYNC; i++) begin
         m_lock_q.push_back(1'b0);
         m_init_q.push_back(1'b0);
      end
      m_rel  = 1'b0;
      m_age  = 0;
      m_qual = 0;
      m_dead = 1'b0;
      m_loss = 0;
   endfunction

   function automatic void model_edge(input bit lk, input bit id, input bit clr);
      bit ls;
      bit is_;
      ls  = m_lock_q[SYNC-1];
      is_ = m_init_q[SYNC-1];
      m_lock_q.push_front(lk);
      m_init_q.push_front(id);
      void'(m_lock_q.pop_back());
      void'(m_init_q.pop_back());
      if (m_dead) begin
         m_dead = 1'b0;
         m_qual = 0;
      end else if (m_rel) begin
         if (!ls) begin
            m_rel  = 1'b0;
            m_dead = 1'b1;
            if (m_loss < LOSS_MAX) m_loss = m_loss + 1;
         end else begin
            m_age = m_age + 1;
         end
      end else if (ls && is_) begin
         m_qual = m_qual + 1;
         if (m_qual == LSC) begin
            m_rel  = 1'b1;
            m_age  = 0;
            m_qual = 0;
         end
      end else begin
         m_qual = 0;
      end
      if (clr) m_loss = 0;
   endfunction

   // Called at a falling edge; drives inputs, advances one rising edge, checks.
   task automatic tick(input bit lk, input bit id, input bit clr);
      PLL_LOCK  = lk;
      INIT_DONE = id;
      LOSS_CLR  = clr;
      @(posedge CLK);
      model_edge(lk, id, clr);
      cyc++;
      #1;
      chk("outs", outs(), model_outs());
      @(negedge CLK);
   endtask

   task automatic run_to(input int target, input bit lk, input bit id);
      while (cyc < target) tick(lk, id, 1'b0);
   endtask

   task automatic do_reset();
      RESETN = 1'b0;
      #1;
      chk("async_rst", outs(), 32'd0);
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESETN = 1'b1;
   endtask

   initial begin
      RESETN    = 1'b0;
      PLL_LOCK  = 1'b0;
      INIT_DONE = 1'b0;
      LOSS_CLR  = 1'b0;
      model_reset();
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_state", outs(), 32'd0);
      @(negedge CLK);
      RESETN = 1'b1;
      cyc = 0;
      run_to(5, 1'b0, 1'b0);
      chk("idle", outs(), 32'd0);

      // Power-up with lock and init together, then loss and recovery in S_RUN.
      cyc = 0;
      run_to(1025, 1'b1, 1'b1);
      chk("fab_pre", 32'(FABRIC_RESET_N), 32'd0);
      chk("stable_pre", 32'(LOCK_STABLE), 32'd0);
      run_to(1026, 1'b1, 1'b1);
      chk("fab_rise", 32'(FABRIC_RESET_N), 32'd1);
      chk("stable_rise", 32'(LOCK_STABLE), 32'd1);
      chk("pipe_held", 32'(PIPE_RESET_N), 32'd0);
      run_to(1041, 1'b1, 1'b1);
      chk("pipe_pre", 32'(PIPE_RESET_N), 32'd0);
      run_to(1042, 1'b1, 1'b1);
      chk("pipe_rise", 32'(PIPE_RESET_N), 32'd1);
      run_to(2000, 1'b1, 1'b1);
      run_to(2002, 1'b0, 1'b1);
      chk("run_still", 32'({FABRIC_RESET_N, PIPE_RESET_N}), 32'd3);
      run_to(2003, 1'b0, 1'b1);
      chk("loss_outs", outs(), 32'd1);
      run_to(2100, 1'b0, 1'b1);
      run_to(3125, 1'b1, 1'b1);
      chk("refab_pre", 32'(FABRIC_RESET_N), 32'd0);
      run_to(3126, 1'b1, 1'b1);
      chk("refab_rise", 32'(FABRIC_RESET_N), 32'd1);
      run_to(3141, 1'b1, 1'b1);
      chk("repipe_pre", 32'(PIPE_RESET_N), 32'd0);
      run_to(3142, 1'b1, 1'b1);
      chk("repipe_rise", 32'(PIPE_RESET_N), 32'd1);

      // INIT_DONE arriving late.
      do_reset();
      cyc = 0;
      run_to(500, 1'b1, 1'b0);
      run_to(1525, 1'b1, 1'b1);
      chk("late_pre", 32'(FABRIC_RESET_N), 32'd0);
      run_to(1526, 1'b1, 1'b1);
      chk("late_rise", 32'(FABRIC_RESET_N), 32'd1);
      chk("late_loss", 32'(LOSS_CNT), 32'd0);

      // Lock glitch during qualification, then loss during stagger.
      do_reset();
      cyc = 0;
      run_to(600, 1'b1, 1'b1);
      run_to(603, 1'b0, 1'b1);
      run_to(1628, 1'b1, 1'b1);
      chk("glitch_pre", 32'(FABRIC_RESET_N), 32'd0);
      run_to(1629, 1'b1, 1'b1);
      chk("glitch_rise", 32'(FABRIC_RESET_N), 32'd1);
      chk("glitch_loss", 32'(LOSS_CNT), 32'd0);
      run_to(1634, 1'b1, 1'b1);
      run_to(1637, 1'b0, 1'b1);
      chk("stg_loss_outs", outs(), 32'd1);
      run_to(1700, 1'b0, 1'b1);

      // Four more loss events saturate the 2-bit counter.
      for (int e = 0; e < 4; e++) begin
         cyc = 0;
         run_to(1100, 1'b1, 1'b1);
         run_to(1110, 1'b0, 1'b1);
      end
      chk("sat_cnt", 32'(LOSS_CNT), 32'd3);

      // Sixth loss with a coincident clear.
      cyc = 0;
      run_to(1102, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      chk("clr_before", 32'({FABRIC_RESET_N, LOSS_CNT}), 32'({1'b1, 2'd3}));
      tick(1'b0, 1'b1, 1'b1);
      chk("clr_wins", outs(), 32'd0);
      run_to(1115, 1'b0, 1'b1);

      // Async reset in the middle of the stagger window.
      cyc = 0;
      run_to(1100, 1'b1, 1'b1);
      run_to(1110, 1'b0, 1'b1);
      chk("loss_one", 32'(LOSS_CNT), 32'd1);
      cyc = 0;
      run_to(1031, 1'b1, 1'b1);
      chk("mid_stagger", 32'({FABRIC_RESET_N, PIPE_RESET_N, LOCK_STABLE}), 32'b101);
      do_reset();

      // Random lock/init/clear activity.
      cyc = 0;
      for (int s = 0; s < 40; s++) begin
         int kind;
         int len;
         bit lk;
         bit id;
         kind = $urandom_range(0, 9);
         lk   = ($urandom_range(0, 3) != 0);
         id   = ($urandom_range(0, 4) != 0);
         if (kind < 3)      len = $urandom_range(1, 6);
         else if (kind < 7) len = $urandom_range(1000, 1080);
         else               len = $urandom_range(20, 300);
         for (int i = 0; i < len; i++) tick(lk, id, $urandom_range(0, 63) == 0);
         if ($urandom_range(0, 19) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
